// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu - load/store unit
//
// Accepts a LOAD/STORE request from the ALU stage. It performs one
// request/acknowledge transfer on the data bus and reports completion with a
// single-cycle done pulse. It handles byte-lane steering for stores and
// sign/zero extension for loads.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   : a misaligned halfword or word access is
//                                     rejected with err, and no bus cycle is
//                                     issued.
//                         undefined : a misaligned address is forced to
//                                     natural alignment and the access
//                                     proceeds.
//
// Every output comes straight from a register. There is no combinational
// path from mem_ack or mem_rdata to any output.
// ---------------------------------------------------------------------------
module lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Captured request and bus registers
    logic        r_err;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_sel;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_load_data;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    // Request decode
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [1:0]  w_size;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_funct3_bad;
    logic        w_misalign;
    logic        w_align_err;
    logic        w_reject;
    logic [1:0]  w_off;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;

    // Load extraction
    logic [15:0] w_lane;
    logic [31:0] w_load_ext;

    // Instruction fields this unit never looks at
    logic        w_unused;
    assign w_unused = ^{instruction[31:15], instruction[11:7]};

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_size   = w_funct3[1:0];

    // Classify the request and decide whether it is rejected
    always_comb begin
        w_is_load    = (w_opcode == OPC_LOAD);
        w_is_store   = (w_opcode == OPC_STORE);
        w_funct3_bad = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                       (w_funct3 == 3'b111) || (w_is_store && w_funct3[2]);
        w_misalign   = ((w_size == 2'b01) && addr[0]) ||
                       ((w_size == 2'b10) && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
        w_align_err  = w_misalign;
`else
        w_align_err  = 1'b0;
`endif
        w_reject     = !(w_is_load || w_is_store) || w_funct3_bad || w_align_err;
    end

    // Naturally aligned byte offset, lane enables and replicated store data
    always_comb begin
        w_off   = addr[1:0];
        w_sel   = 4'b1111;
        w_wdata = store_data;
        unique case (w_size)
            2'b00: begin
                w_off   = addr[1:0];
                w_sel   = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                // addr[0] is dropped here. In the trap build it never reaches
                // the bus, because the request was already rejected.
                w_off   = {addr[1], 1'b0};
                w_sel   = 4'b0011 << {addr[1], 1'b0};
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_off   = 2'b00;
                w_sel   = 4'b1111;
                w_wdata = store_data;
            end
        endcase
    end

    // Select the addressed lane(s) of the read word, then extend them
    always_comb begin
        unique case (r_off)
            2'd0:    w_lane = mem_rdata[15:0];
            2'd1:    w_lane = mem_rdata[23:8];
            2'd2:    w_lane = mem_rdata[31:16];
            default: w_lane = {8'h00, mem_rdata[31:24]};
        endcase
        unique case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load_ext = {24'h000000, w_lane[7:0]};
            3'b001:  w_load_ext = {{16{w_lane[15]}}, w_lane};
            3'b101:  w_load_ext = {16'h0000, w_lane};
            default: w_load_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_reject ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the accepted request and the load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_sel   <= '0;
            r_mem_wdata <= '0;
            r_load_data <= '0;
            r_funct3    <= '0;
            r_off       <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_err <= w_reject;
                if (!w_reject) begin
                    r_mem_we    <= w_is_store;
                    r_mem_addr  <= {addr[31:2], 2'b00};
                    r_mem_sel   <= w_sel;
                    r_mem_wdata <= w_wdata;
                    r_funct3    <= w_funct3;
                    r_off       <= w_off;
                end
            end
            if ((r_state == S_REQ) && mem_ack && !r_mem_we) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    // mem_req and done decode directly from the state register, so an
    // asynchronous reset drops them immediately.
    assign busy      = (r_state != S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign done      = (r_state == S_RESP);
    assign err       = (r_state == S_RESP) && r_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_sel   = r_mem_sel;
    assign mem_wdata = r_mem_wdata;
    assign load_data = r_load_data;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu - directed self-checking bench for lsu.
// A transaction-level model predicts the outputs, and a compare process
// checks them on every falling clock edge. The directed vectors also carry
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_lsu;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instruction;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .addr        (addr),
        .store_data  (store_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .load_data   (load_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_sel     (mem_sel),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int unsigned f3, input logic [6:0] op);
        logic [2:0] f;
        f = 3'(f3);
        return {17'h0, f, 5'h0, op};
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        ok;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [1:0]  off;
    } acc_t;

    function automatic acc_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] sd);
        acc_t        r;
        logic [6:0]  op;
        logic [2:0]  f3;
        int unsigned sz;
        logic [31:0] ea;
        logic        is_ld;
        logic        is_st;
        r     = '0;
        op    = ins[6:0];
        f3    = ins[14:12];
        sz    = int'(f3[1:0]);
        is_ld = (op == LD);
        is_st = (op == ST);
        r.ok  = (is_ld || is_st) && (f3 != 3'd3) && (f3 < 3'd6) && !(is_st && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 1 && a[0]) r.ok = 1'b0;
        if (sz == 2 && a[1:0] != 2'b00) r.ok = 1'b0;
`endif
        ea = a;
        if (sz == 1) ea = a & ~32'd1;
        else if (sz == 2) ea = a & ~32'd3;
        r.we   = is_st;
        r.addr = ea & ~32'd3;
        r.off  = ea[1:0];
        r.f3   = f3;
        if (sz == 0) begin
            r.sel   = 4'(1 << ea[1:0]);
            r.wdata = {24'h0, sd[7:0]} * 32'h0101_0101;
        end else if (sz == 1) begin
            r.sel   = 4'(3 << ea[1:0]);
            r.wdata = {16'h0, sd[15:0]} * 32'h0001_0001;
        end else begin
            r.sel   = 4'hF;
            r.wdata = sd;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        case (f3)
            3'd0: begin v = v & 32'd255;   if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
            3'd4: v = v & 32'd255;
            3'd1: begin v = v & 32'd65535; if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
            3'd5: v = v & 32'd65535;
            default: v = rd;
        endcase
        return v;
    endfunction

    // phase: 0 idle, 1 bus transfer outstanding, 2 completion cycle
    int          m_phase;
    acc_t        m_acc;
    acc_t        m_dec;
    logic [31:0] m_ld;
    logic        m_err;

    always_comb m_dec = ref_decode(instruction, addr, store_data);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_acc   <= '0;
            m_ld    <= '0;
            m_err   <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_err   <= !m_dec.ok;
                    m_phase <= m_dec.ok ? 1 : 2;
                    if (m_dec.ok) m_acc <= m_dec;
                end
                1: if (mem_ack) begin
                    m_phase <= 2;
                    if (!m_acc.we) m_ld <= ref_load(m_acc.f3, m_acc.off, mem_rdata);
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Compare DUT against model on each falling edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
            chk("done", 32'(done), 32'(m_phase == 2));
            chk("err", 32'(err), 32'(m_phase == 2 && m_err));
            if (m_phase == 1) begin
                chk("mem_addr", mem_addr, m_acc.addr);
                chk("mem_sel", 32'(mem_sel), 32'(m_acc.sel));
                chk("mem_we", 32'(mem_we), 32'(m_acc.we));
                if (m_acc.we) chk("mem_wdata", mem_wdata, m_acc.wdata);
            end else begin
                chk("load_data", load_data, m_ld);
            end
        end
    end

    // One access with fixed-latency slave; literal expectations.
    task automatic xact(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] sd,
                        input int waits, input logic [31:0] rd, input bit exp_bus,
                        input logic [31:0] e_addr, input logic [3:0] e_sel, input bit e_we,
                        input logic [31:0] e_wd, input logic [31:0] e_ld);
        @(posedge clk); #1;
        start = 1'b1; instruction = ins; addr = a; store_data = sd;
        @(posedge clk); #1;
        start = 1'b0; instruction = 32'h0; addr = 32'hFFFF_FFFF; store_data = 32'h0;
        if (exp_bus) begin
            chk("c1_req", 32'(mem_req), 32'd1);
            chk("c1_busy", 32'(busy), 32'd1);
            chk("c1_addr", mem_addr, e_addr);
            chk("c1_sel", 32'(mem_sel), 32'(e_sel));
            chk("c1_we", 32'(mem_we), 32'(e_we));
            if (e_we) chk("c1_wdata", mem_wdata, e_wd);
            for (int i = 0; i < waits; i++) begin
                @(posedge clk); #1;
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_addr", mem_addr, e_addr);
                chk("hold_sel", 32'(mem_sel), 32'(e_sel));
                chk("hold_we", 32'(mem_we), 32'(e_we));
                if (e_we) chk("hold_wdata", mem_wdata, e_wd);
            end
            mem_ack = 1'b1; mem_rdata = rd;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk("fin_done", 32'(done), 32'd1);
            chk("fin_err", 32'(err), 32'd0);
            chk("fin_req", 32'(mem_req), 32'd0);
            chk("fin_ld", load_data, e_ld);
        end else begin
            chk("rej_done", 32'(done), 32'd1);
            chk("rej_err", 32'(err), 32'd1);
            chk("rej_req", 32'(mem_req), 32'd0);
            chk("rej_ld", load_data, e_ld);
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [31:0] LD_AFTER_MIS = 32'h0000_8001;
`else
    localparam logic [31:0] LD_AFTER_MIS = 32'hFFFF_C3D4;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        start = 1'b0; instruction = '0; addr = '0; store_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_sel", 32'(mem_sel), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_ld", load_data, 32'd0);
        rst_n = 1'b1;

        xact(mk(2, LD), 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, 1, 32'h1004, 4'hF, 0, 32'h0, 32'hDEAD_BEEF);
        xact(mk(0, LD), 32'h0000_1003, 32'h0, 0, 32'h80FF_FF7F, 1, 32'h1000, 4'b1000, 0, 32'h0, 32'hFFFF_FF80);
        xact(mk(4, LD), 32'h0000_1003, 32'h0, 0, 32'h80FF_FF7F, 1, 32'h1000, 4'b1000, 0, 32'h0, 32'h0000_0080);
        xact(mk(1, ST), 32'h0000_2002, 32'h1234_ABCD, 3, 32'h0, 1, 32'h2000, 4'b1100, 1, 32'hABCD_ABCD, 32'h0000_0080);
        xact(mk(0, 7'b0110011), 32'h0000_1000, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_0080);
        xact(mk(1, LD), 32'h0000_1002, 32'h0, 0, 32'h8001_1234, 1, 32'h1000, 4'b1100, 0, 32'h0, 32'hFFFF_8001);
        xact(mk(5, LD), 32'h0000_1002, 32'h0, 0, 32'h8001_1234, 1, 32'h1000, 4'b1100, 0, 32'h0, 32'h0000_8001);
        xact(mk(0, ST), 32'h0000_3001, 32'h0000_0055, 0, 32'h0, 1, 32'h3000, 4'b0010, 1, 32'h5555_5555, 32'h0000_8001);
        xact(mk(2, ST), 32'h0000_4000, 32'hCAFE_F00D, 1, 32'h0, 1, 32'h4000, 4'hF, 1, 32'hCAFE_F00D, 32'h0000_8001);
        xact(mk(4, ST), 32'h0000_4000, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_8001);
        xact(mk(3, LD), 32'h0000_4000, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_8001);
        xact(mk(6, LD), 32'h0000_4000, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_8001);
        xact(mk(7, ST), 32'h0000_4000, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_8001);
`ifdef LSU_MISALIGN_TRAP_EN
        xact(mk(2, LD), 32'h0000_1002, 32'h0, 0, 32'h1122_3344, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_8001);
        xact(mk(1, LD), 32'h0000_1001, 32'h0, 0, 32'hA5A5_C3D4, 0, 32'h0, 4'h0, 0, 32'h0, 32'h0000_8001);
`else
        xact(mk(2, LD), 32'h0000_1002, 32'h0, 0, 32'h1122_3344, 1, 32'h1000, 4'hF, 0, 32'h0, 32'h1122_3344);
        xact(mk(1, LD), 32'h0000_1001, 32'h0, 0, 32'hA5A5_C3D4, 1, 32'h1000, 4'b0011, 0, 32'h0, 32'hFFFF_C3D4);
`endif
        xact(mk(0, ST), 32'h0000_3002, 32'hFFFF_FF9A, 2, 32'h0, 1, 32'h3000, 4'b0100, 1, 32'h9A9A_9A9A, LD_AFTER_MIS);
`ifdef LSU_MISALIGN_TRAP_EN
        xact(mk(2, ST), 32'h0000_4001, 32'h0102_0304, 0, 32'h0, 0, 32'h0, 4'h0, 0, 32'h0, LD_AFTER_MIS);
`else
        xact(mk(2, ST), 32'h0000_4001, 32'h0102_0304, 0, 32'h0, 1, 32'h4000, 4'hF, 1, 32'h0102_0304, LD_AFTER_MIS);
`endif

        // start held high while busy is ignored; ack outside REQ is ignored
        @(posedge clk); #1;
        start = 1'b1; instruction = mk(2, LD); addr = 32'h0000_5008;
        @(posedge clk); #1;
        addr = 32'h0000_6000;
        chk("busy_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        chk("busy_addr", mem_addr, 32'h0000_5008);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b0;
        chk("busy_done", 32'(done), 32'd1);
        chk("busy_ld", load_data, 32'h0BAD_F00D);
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_done", 32'(done), 32'd0);
        chk("stray_ack_ld", load_data, 32'h0BAD_F00D);

        // asynchronous reset during REQ with ack withheld
        @(posedge clk); #1;
        start = 1'b1; instruction = mk(2, ST); addr = 32'h0000_7000; store_data = 32'h1111_2222;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ar_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_err", 32'(err), 32'd0);
        chk("ar_we", 32'(mem_we), 32'd0);
        chk("ar_sel", 32'(mem_sel), 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        chk("ar_wdata", mem_wdata, 32'd0);
        chk("ar_ld", load_data, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("late_ack_done", 32'(done), 32'd0);
            chk("late_ack_ld", load_data, 32'd0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the ALU in the CPU datapath. It takes the effective address the ALU computes for LOAD/STORE opcodes, together with the instruction and the rs2 value, and runs one request/acknowledge transaction on the data memory bus. It performs byte-lane steering for stores and sign/zero extension for loads, then reports completion to the control sequencer and the register-file writeback path.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `instruction`  in  32  instruction word; uses opcode [6:0] and funct3 [14:12].
- `addr`  in  32  effective address, i.e. the ALU result.
- `store_data`  in  32  rs2 value for stores.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  single-cycle completion pulse.
- `err`  out  1  valid with `done`; access rejected, no bus cycle was issued.
- `load_data`  out  32  extended load result; valid from `done` until the next accepted `start`.
- `mem_req`  out  1  bus request; held until acknowledged.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned bus address; [1:0] is always 0.
- `mem_sel`  out  4  byte-lane enables; bit n selects bits [8n+7:8n].
- `mem_wdata`  out  32  lane-steered write data.
- `mem_ack`  in  1  transfer complete; sampled only while `mem_req` is high.
- `mem_rdata`  in  32  read data; valid in the `mem_ack` cycle.

## Operation
- States:
  - IDLE: `start` = 1 moves to REQ, or to RESP with `err` if the request is rejected.
  - REQ: `mem_ack` moves to RESP.
  - RESP: unconditional return to IDLE.
- Request decode on `start`:
  - Opcode 0000011 is a load; opcode 0100011 is a store.
  - Any other opcode is rejected.
  - funct3 values 011, 110 and 111 are rejected. funct3 100 and 101 are rejected for stores.
- A rejected request goes IDLE → RESP with `err` = 1. It issues no bus cycle and leaves `load_data` unchanged.
- Bus outputs are registered on acceptance and held stable throughout REQ:
  - `mem_addr` = {addr[31:2], 2'b00}.
  - Byte: `mem_sel` = 4'b0001 << addr[1:0].
  - Half: `mem_sel` = 4'b0011 << {addr[1], 1'b0}.
  - Word: `mem_sel` = 4'b1111.
- Store data is replicated across lanes: byte as {4{b}}, half as {2{h}}, word unchanged.
- Load extraction captures `mem_rdata` on the ack edge:
  - Select the lane(s) at offset addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `mem_ack` outside REQ is ignored.
- `start` while `busy` is high is ignored; no queuing.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: `mem_req` = 1 and `busy` = 1.
- Cycle k ≥ 1: first cycle with `mem_ack` high. Cycle k+1: `done` = 1 and `load_data` valid; `mem_req` = 0.
- Minimum latency is therefore 2 cycles from `start` to `done` with a zero-wait-state slave.
- A rejected request raises `done` and `err` in cycle 1.
- `done` and `err` are high for exactly one cycle. The next `start` is accepted in the cycle after `done`, so throughput is one access per 3 cycles.
- No combinational path from `mem_ack` or `mem_rdata` to any output.
- Reset values: `busy`, `done`, `err`, `mem_req`, `mem_we` are 0; `mem_sel` = 4'h0; `mem_addr`, `mem_wdata`, `load_data` are 32'h0; state is IDLE.
- Reset asserted mid-REQ drops `mem_req` immediately (asynchronously). A late `mem_ack` after reset release is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A halfword access with addr[0] = 1 is rejected with `err`, with no bus cycle.
  - A word access with addr[1:0] ≠ 0 is rejected the same way.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned addresses are forced to natural alignment: halfword clears addr[0], word clears addr[1:0].
  - The access then proceeds normally; `err` is asserted only for invalid opcode or funct3.

## Test plan
- LW, addr 32'h0000_1004, zero-wait slave returning 32'hDEAD_BEEF:
  - `mem_req` in cycle 1 with `mem_addr` 32'h1004 and `mem_sel` 4'hF.
  - `done` in cycle 2 with `load_data` 32'hDEAD_BEEF.
- LB at addr 32'h1003, `mem_rdata` 32'h80FF_FF7F: `load_data` = 32'hFFFF_FF80. LBU at the same address returns 32'h0000_0080.
- SH, addr 32'h2002, `store_data` 32'h1234_ABCD, slave with 3 wait states:
  - `mem_we` = 1, `mem_sel` = 4'b1100, `mem_wdata` = 32'hABCD_ABCD.
  - All four held stable for 4 cycles; `done` 1 cycle after ack.
- LW at addr 32'h1002:
  - With `LSU_MISALIGN_TRAP_EN`: `done` and `err` in cycle 1, `mem_req` never asserted.
  - Without it: bus access at 32'h1000 and `err` = 0.
- Opcode 0110011 with `start`: `done` and `err` in cycle 1, no bus cycle, `load_data` unchanged.
- Assert `rst_n` low during REQ with ack withheld:
  - `mem_req` falls without waiting for a clock edge; all outputs take reset values.
  - A `mem_ack` pulse after release produces no `done`.
